// File: rtl/gc_tx_sequencer_if.sv
// Host-side and encoder-side signal bundle for the GC/N64 transmit sequencer.
// slave = sequencer view, master = host/encoder view.
interface gc_tx_sequencer_if;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] tx_len;
    logic       start;
    logic       busy;
    logic       done;
    logic       err;
    logic       bit_trigger;
    logic [1:0] bit_digit;
    logic       bit_busy;

    modport slave (
        input  wr_en, wr_addr, wr_data, tx_len, start, bit_busy,
        output busy, done, err, bit_trigger, bit_digit
    );

    modport master (
        output wr_en, wr_addr, wr_data, tx_len, start, bit_busy,
        input  busy, done, err, bit_trigger, bit_digit
    );
endinterface

// File: rtl/gc_tx_sequencer.sv
// Frame transmit controller: walks a byte buffer MSB-first and hands one
// symbol at a time to the single-wire bit encoder, then a stop symbol.
module gc_tx_sequencer #(
    parameter int MAX_BYTES   = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    gc_tx_sequencer_if.slave    bus
);
    localparam int         CW   = $clog2(ACK_TIMEOUT + 1);
    localparam logic [3:0] MAXB = 4'(MAX_BYTES);

    typedef enum logic [2:0] {
        IDLE, SETUP, TRIG, WAIT_ACK, WAIT_DONE, FIN
    } state_t;

    state_t         state_q, state_d;
    logic [6:0]     idx_q, idx_d;
    logic [3:0]     len_q, len_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           err_q, err_d;
    logic [7:0]     buf_q [8];

    logic           busy_w;
    logic           last_sym;
    logic           bad_len;
    logic           wr_ok;
    logic [7:0]     cur_byte;
    logic           cur_bit;

    assign busy_w   = (state_q != IDLE) && (state_q != FIN);
    assign last_sym = (idx_q == {len_q, 3'b000});
    assign bad_len  = (bus.tx_len == 4'd0) || (bus.tx_len > MAXB);
    assign wr_ok    = bus.wr_en && !busy_w && ({1'b0, bus.wr_addr} < MAXB);
    assign cur_byte = buf_q[idx_q[5:3]];
    assign cur_bit  = cur_byte[3'd7 - idx_q[2:0]];

    // Digit is a pure function of the frozen index, so it stays put
    // from SETUP through WAIT_DONE and falls back to stop when idle.
    assign bus.busy        = busy_w;
    assign bus.done        = (state_q == FIN);
    assign bus.err         = err_q;
    assign bus.bit_trigger = (state_q == TRIG);
    assign bus.bit_digit   = (busy_w && !last_sym) ? {1'b0, cur_bit} : 2'b11;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bad_len) begin
                        err_d = 1'b1;
                    end else begin
                        len_d   = bus.tx_len;
                        idx_d   = 7'd0;
                        state_d = SETUP;
                    end
                end
            end
            SETUP: state_d = TRIG;
            TRIG: begin
                cnt_d   = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                // Ack wins over the final timeout count.
                if (bus.bit_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_DONE: begin
                if (!bus.bit_busy) begin
                    if (last_sym) begin
                        state_d = FIN;
                    end else begin
                        idx_d   = idx_q + 7'd1;
                        state_d = SETUP;
                    end
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            idx_q   <= 7'd0;
            len_q   <= 4'd0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < 8; i++) buf_q[i] <= 8'h00;
        end else if (wr_ok) begin
            buf_q[bus.wr_addr] <= bus.wr_data;
        end
    end
endmodule
